// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter merging several cbus requesters onto one downstream cbus.
// Grant is held for one whole transaction and released on the final response beat.

package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

// state | meaning
// IDLE  | no grant; outputs quiet, picks next winner from ptr onwards
// BUSY  | port sel owns the downstream bus until ready && last
module cbus_rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int PRIO_INIT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  cbus_pkg::cbus_req_t  ireqs  [NUM_PORTS],
    output cbus_pkg::cbus_resp_t iresps [NUM_PORTS],
    output cbus_pkg::cbus_req_t  oreq,
    input  cbus_pkg::cbus_resp_t oresp
);

    localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   winner;
    logic               any_valid;

    // base + off with wrap at NUM_PORTS; off is always below NUM_PORTS here
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int off);
        int s;
        s = int'({1'b0, base}) + off;
        if (s >= NUM_PORTS) begin
            s = s - NUM_PORTS;
        end
        return SEL_W'(s);
    endfunction

    always_comb begin
        any_valid = 1'b0;
        winner    = ptr_q;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!any_valid && ireqs[wrap_add(ptr_q, k)].valid) begin
                any_valid = 1'b1;
                winner    = wrap_add(ptr_q, k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    sel_d   = winner;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // a requester dropping valid early does not release the grant
                if (oresp.ready && oresp.last) begin
                    state_d = IDLE;
                    ptr_d   = wrap_add(sel_q, 1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        oreq = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            iresps[j] = '0;
        end
        if (state_q == BUSY) begin
            oreq = ireqs[sel_q];
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (sel_q == SEL_W'(j)) begin
                    iresps[j] = oresp;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= SEL_W'(PRIO_INIT);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule
